// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Arbitrates the single Common Data Bus between result producers: the ALU
// reservation stations (indices 0..N_REQ-2) and the load/store queue
// (index N_REQ-1). At most one producer is granted per cycle, round-robin,
// and the winner's ROB tag, value and branch outcome are broadcast on the
// following clock edge.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester "result available"
//   req_tag       per-requester ROB tag, slice i = [i*TAG_W +: TAG_W]
//   req_value     per-requester result, slice i = [i*DATA_W +: DATA_W]
//   req_br_taken  per-requester resolved branch outcome
//   req_ready     one-hot grant (combinational, zero while in reset)
//   flush         mispredict flush: no grant this cycle
//   cdb_valid     registered broadcast valid
//   cdb_tag       registered broadcast ROB tag
//   cdb_value     registered broadcast value
//   cdb_br_taken  registered broadcast branch outcome
//   cdb_src       registered index of the granted requester
//   err_tag0      sticky: a valid request was presented with tag 0
//
// Build option:
//   CDB_LOAD_PRIORITY_EN  when defined, the LSQ wins whenever eligible
//                         (without moving the round-robin pointer), bounded
//                         by a starvation counter that masks the LSQ for one
//                         arbitration after 8 contested wins.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int N_REQ  = 5,
   parameter int TAG_W  = 4,
   parameter int DATA_W = 32,
   parameter int SRC_W  = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*TAG_W-1:0]    req_tag,
   input  logic [N_REQ*DATA_W-1:0]   req_value,
   input  logic [N_REQ-1:0]          req_br_taken,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      flush,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_value,
   output logic                      cdb_br_taken,
   output logic [SRC_W-1:0]          cdb_src,
   output logic                      err_tag0
);

   localparam logic [SRC_W-1:0] LSQ_IDX = SRC_W'(N_REQ - 1);

   // Tag 0 marks an invalid ROB entry and can never be broadcast.
   function automatic logic tag_is_zero(input logic [TAG_W-1:0] tag);
      return (tag == {TAG_W{1'b0}});
   endfunction

   logic [N_REQ-1:0]  tag0_hit_s;
   logic [N_REQ-1:0]  elig_s;
   logic [N_REQ-1:0]  arb_elig_s;
   logic [N_REQ-1:0]  grant_s;
   logic              lsq_prio_s;
   logic              hi_found_s;
   logic              lo_found_s;
   logic [SRC_W-1:0]  hi_idx_s;
   logic [SRC_W-1:0]  lo_idx_s;
   logic              win_found_s;
   logic [SRC_W-1:0]  win_idx_s;
   logic [SRC_W-1:0]  rr_next_s;
   logic              transfer_s;
   logic              ptr_upd_s;
   logic [TAG_W-1:0]  sel_tag_s;
   logic [DATA_W-1:0] sel_value_s;
   logic              sel_br_s;

   logic [SRC_W-1:0]  rr_ptr_r;
   logic              cdb_valid_r;
   logic [TAG_W-1:0]  cdb_tag_r;
   logic [DATA_W-1:0] cdb_value_r;
   logic              cdb_br_taken_r;
   logic [SRC_W-1:0]  cdb_src_r;
   logic              err_tag0_r;

   // Eligibility: valid, non-zero tag, and no flush in progress.
   always_comb begin
      tag0_hit_s = {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         tag0_hit_s[i] = req_valid[i] & tag_is_zero(req_tag[i*TAG_W +: TAG_W]);
      end
      elig_s = req_valid & ~tag0_hit_s & {N_REQ{~flush}};
   end

`ifdef CDB_LOAD_PRIORITY_EN
   logic [3:0] starve_cnt_r;
   logic       lsq_mask_s;
   logic       others_elig_s;

   // After 8 contested LSQ wins the LSQ sits out one arbitration.
   assign lsq_mask_s    = (starve_cnt_r == 4'd8);
   assign others_elig_s = |elig_s[N_REQ-2:0];
   assign lsq_prio_s    = elig_s[N_REQ-1] & ~lsq_mask_s;
   assign arb_elig_s    = elig_s & {~lsq_mask_s, {(N_REQ-1){1'b1}}};

   // Starvation counter: counts LSQ wins that blocked another eligible requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_r <= 4'd0;
      end else if (lsq_mask_s) begin
         starve_cnt_r <= 4'd0;
      end else if (lsq_prio_s && others_elig_s) begin
         starve_cnt_r <= starve_cnt_r + 4'd1;
      end
   end
`else
   assign lsq_prio_s = 1'b0;
   assign arb_elig_s = elig_s;
`endif

   // Round-robin search split in two: first eligible at or above the pointer,
   // else first eligible from index 0 (the wrap-around case). Scanning from
   // the top down lets the lowest matching index win.
   always_comb begin
      hi_found_s = 1'b0;
      hi_idx_s   = {SRC_W{1'b0}};
      lo_found_s = 1'b0;
      lo_idx_s   = {SRC_W{1'b0}};
      for (int i = N_REQ - 1; i >= 0; i--) begin
         hi_found_s = (arb_elig_s[i] && (SRC_W'(i) >= rr_ptr_r)) ? 1'b1 : hi_found_s;
         hi_idx_s   = (arb_elig_s[i] && (SRC_W'(i) >= rr_ptr_r)) ? SRC_W'(i) : hi_idx_s;
         lo_found_s = arb_elig_s[i] ? 1'b1 : lo_found_s;
         lo_idx_s   = arb_elig_s[i] ? SRC_W'(i) : lo_idx_s;
      end
   end

   // Winner selection: LSQ priority (if built in), then round-robin.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = {SRC_W{1'b0}};
      if (lsq_prio_s) begin
         win_found_s = 1'b1;
         win_idx_s   = LSQ_IDX;
      end else if (hi_found_s) begin
         win_found_s = 1'b1;
         win_idx_s   = hi_idx_s;
      end else if (lo_found_s) begin
         win_found_s = 1'b1;
         win_idx_s   = lo_idx_s;
      end else begin
         win_found_s = 1'b0;
         win_idx_s   = {SRC_W{1'b0}};
      end
   end

   assign grant_s    = win_found_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s) : {N_REQ{1'b0}};
   // Grants are suppressed while reset is asserted.
   assign req_ready  = grant_s & {N_REQ{rst_n}};
   assign transfer_s = |(req_valid & req_ready);
   assign rr_next_s  = (win_idx_s == LSQ_IDX) ? {SRC_W{1'b0}} : (win_idx_s + SRC_W'(1));
   // A priority LSQ win leaves the round-robin order untouched.
   assign ptr_upd_s  = transfer_s & ~lsq_prio_s;

   // Payload mux driven by the one-hot grant.
   always_comb begin
      sel_tag_s   = {TAG_W{1'b0}};
      sel_value_s = {DATA_W{1'b0}};
      sel_br_s    = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_tag_s   = sel_tag_s   | (grant_s[i] ? req_tag[i*TAG_W +: TAG_W]     : {TAG_W{1'b0}});
         sel_value_s = sel_value_s | (grant_s[i] ? req_value[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
         sel_br_s    = sel_br_s    | (grant_s[i] & req_br_taken[i]);
      end
   end

   // Round-robin pointer: moves past the winner, holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= {SRC_W{1'b0}};
      end else if (ptr_upd_s) begin
         rr_ptr_r <= rr_next_s;
      end
   end

   // Broadcast register: payload captured on transfer, held when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdb_valid_r    <= 1'b0;
         cdb_tag_r      <= {TAG_W{1'b0}};
         cdb_value_r    <= {DATA_W{1'b0}};
         cdb_br_taken_r <= 1'b0;
         cdb_src_r      <= {SRC_W{1'b0}};
      end else begin
         cdb_valid_r <= transfer_s;
         if (transfer_s) begin
            cdb_tag_r      <= sel_tag_s;
            cdb_value_r    <= sel_value_s;
            cdb_br_taken_r <= sel_br_s;
            cdb_src_r      <= win_idx_s;
         end
      end
   end

   // Sticky tag-0 error flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_tag0_r <= 1'b0;
      end else if (|tag0_hit_s) begin
         err_tag0_r <= 1'b1;
      end
   end

   assign cdb_valid    = cdb_valid_r;
   assign cdb_tag      = cdb_tag_r;
   assign cdb_value    = cdb_value_r;
   assign cdb_br_taken = cdb_br_taken_r;
   assign cdb_src      = cdb_src_r;
   assign err_tag0     = err_tag0_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed self-checking bench for cdb_arbiter (N_REQ=5, TAG_W=4, DATA_W=32).
// Inputs change 1 ns after the rising edge; combinational grants and the
// registered broadcast are sampled there as well, away from the edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cdb_arbiter;

   logic         clk;
   logic         rst_n;
   logic [4:0]   req_valid;
   logic [19:0]  req_tag;
   logic [159:0] req_value;
   logic [4:0]   req_br_taken;
   logic [4:0]   req_ready;
   logic         flush;
   logic         cdb_valid;
   logic [3:0]   cdb_tag;
   logic [31:0]  cdb_value;
   logic         cdb_br_taken;
   logic [2:0]   cdb_src;
   logic         err_tag0;

   int vectors;
   int miscompares;

   cdb_arbiter #(.N_REQ(5), .TAG_W(4), .DATA_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_tag      (req_tag),
      .req_value    (req_value),
      .req_br_taken (req_br_taken),
      .req_ready    (req_ready),
      .flush        (flush),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_value    (cdb_value),
      .cdb_br_taken (cdb_br_taken),
      .cdb_src      (cdb_src),
      .err_tag0     (err_tag0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clr_all();
      req_valid    = 5'b0;
      req_tag      = 20'h0;
      req_value    = 160'h0;
      req_br_taken = 5'b0;
   endtask

   task automatic set_req(input int i, input logic [3:0] t, input logic [31:0] v, input logic b);
      req_valid[i]         = 1'b1;
      req_tag[i*4 +: 4]    = t;
      req_value[i*32 +: 32] = v;
      req_br_taken[i]      = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      clr_all();
      set_req(2, 4'd5, 32'h1234_5678, 1'b1);
      #2;
      vectors++; if (req_ready !== 5'b00000) begin miscompares++; $display("FAIL reset_ready: got %b expected %b", req_ready, 5'b00000); end
      vectors++; if (cdb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", cdb_valid); end
      vectors++; if (cdb_tag !== 4'd0 || cdb_value !== 32'd0 || cdb_br_taken !== 1'b0 || cdb_src !== 3'd0)
         begin miscompares++; $display("FAIL reset_payload: got tag=%0d value=%h br=%b src=%0d expected all 0", cdb_tag, cdb_value, cdb_br_taken, cdb_src); end
      vectors++; if (err_tag0 !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err_tag0); end
      clr_all();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // Pointer 0 -> after grant to 2 the pointer is 3.
   task automatic test_single();
      set_req(2, 4'd5, 32'hDEAD_BEEF, 1'b1);
      #1;
      vectors++; if (req_ready !== 5'b00100) begin miscompares++; $display("FAIL single_ready: got %b expected %b", req_ready, 5'b00100); end
      tick();
      clr_all();
      vectors++; if (cdb_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b expected 1", cdb_valid); end
      vectors++; if (cdb_tag !== 4'd5) begin miscompares++; $display("FAIL single_tag: got %0d expected 5", cdb_tag); end
      vectors++; if (cdb_value !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_value: got %h expected deadbeef", cdb_value); end
      vectors++; if (cdb_br_taken !== 1'b1) begin miscompares++; $display("FAIL single_br: got %b expected 1", cdb_br_taken); end
      vectors++; if (cdb_src !== 3'd2) begin miscompares++; $display("FAIL single_src: got %0d expected 2", cdb_src); end
      tick();
      vectors++; if (cdb_valid !== 1'b0) begin miscompares++; $display("FAIL single_idle_valid: got %b expected 0", cdb_valid); end
      vectors++; if (cdb_tag !== 4'd5 || cdb_src !== 3'd2) begin miscompares++; $display("FAIL single_hold: got tag=%0d src=%0d expected tag=5 src=2", cdb_tag, cdb_src); end
   endtask

   // Pointer starts at 3: all requesters valid -> 3,4,0,1,2,3 with no bubbles.
   task automatic test_round_robin();
      int exp_src [6] = '{3, 4, 0, 1, 2, 3};
      logic [4:0] exp_ready;
      for (int i = 0; i < 5; i++) set_req(i, 4'(i + 1), 32'hA000_0000 + 32'(i), i[0]);
      for (int k = 0; k < 6; k++) begin
         exp_ready = 5'b00001 << exp_src[k];
         #1;
         vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_ready); end
         tick();
         vectors++; if (cdb_valid !== 1'b1 || cdb_src !== 3'(exp_src[k]) || cdb_tag !== 4'(exp_src[k] + 1))
            begin miscompares++; $display("FAIL rr_bcast[%0d]: got v=%b src=%0d tag=%0d expected v=1 src=%0d tag=%0d", k, cdb_valid, cdb_src, cdb_tag, exp_src[k], exp_src[k] + 1); end
         vectors++; if (cdb_value !== 32'hA000_0000 + 32'(exp_src[k])) begin miscompares++; $display("FAIL rr_value[%0d]: got %h expected %h", k, cdb_value, 32'hA000_0000 + 32'(exp_src[k])); end
      end
      clr_all();
   endtask

   // Pointer 4: grant 1 (ptr 2), then reqs 0 and 3 -> 3 then 0 (ptr 1).
   task automatic test_pointer();
      set_req(1, 4'd2, 32'h0000_1111, 1'b0);
      #1;
      vectors++; if (req_ready !== 5'b00010) begin miscompares++; $display("FAIL ptr_first_ready: got %b expected %b", req_ready, 5'b00010); end
      tick();
      clr_all();
      set_req(0, 4'd6, 32'h0000_6666, 1'b0);
      set_req(3, 4'd8, 32'h0000_8888, 1'b1);
      #1;
      vectors++; if (req_ready !== 5'b01000) begin miscompares++; $display("FAIL ptr_grant3: got %b expected %b", req_ready, 5'b01000); end
      tick();
      vectors++; if (cdb_src !== 3'd3 || cdb_tag !== 4'd8) begin miscompares++; $display("FAIL ptr_bcast3: got src=%0d tag=%0d expected src=3 tag=8", cdb_src, cdb_tag); end
      req_valid[3] = 1'b0;
      #1;
      vectors++; if (req_ready !== 5'b00001) begin miscompares++; $display("FAIL ptr_grant0: got %b expected %b", req_ready, 5'b00001); end
      tick();
      vectors++; if (cdb_src !== 3'd0 || cdb_tag !== 4'd6) begin miscompares++; $display("FAIL ptr_bcast0: got src=%0d tag=%0d expected src=0 tag=6", cdb_src, cdb_tag); end
      clr_all();
   endtask

   // Pointer 1, broadcast from req 0 on the bus when flush rises.
   task automatic test_flush();
      set_req(1, 4'd3, 32'h0000_3333, 1'b0);
      set_req(4, 4'd9, 32'h0000_9999, 1'b1);
      flush = 1'b1;
      #1;
      vectors++; if (req_ready !== 5'b00000) begin miscompares++; $display("FAIL flush_ready: got %b expected %b", req_ready, 5'b00000); end
      vectors++; if (cdb_valid !== 1'b1 || cdb_src !== 3'd0) begin miscompares++; $display("FAIL flush_no_retract: got v=%b src=%0d expected v=1 src=0", cdb_valid, cdb_src); end
      tick();
      flush = 1'b0;
      vectors++; if (cdb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b expected 0", cdb_valid); end
      #1;
      vectors++; if (req_ready !== 5'b00010) begin miscompares++; $display("FAIL flush_ptr_held: got %b expected %b", req_ready, 5'b00010); end
      tick();
      vectors++; if (cdb_valid !== 1'b1 || cdb_src !== 3'd1) begin miscompares++; $display("FAIL flush_after: got v=%b src=%0d expected v=1 src=1", cdb_valid, cdb_src); end
      clr_all();
      tick();
   endtask

   task automatic test_tag0();
      set_req(0, 4'd0, 32'h0000_0BAD, 1'b0);
      set_req(1, 4'd7, 32'h0000_7777, 1'b1);
      #1;
      vectors++; if (req_ready !== 5'b00010) begin miscompares++; $display("FAIL tag0_ready: got %b expected %b", req_ready, 5'b00010); end
      tick();
      clr_all();
      vectors++; if (err_tag0 !== 1'b1) begin miscompares++; $display("FAIL tag0_err_set: got %b expected 1", err_tag0); end
      vectors++; if (cdb_src !== 3'd1 || cdb_tag !== 4'd7 || cdb_value !== 32'h0000_7777)
         begin miscompares++; $display("FAIL tag0_bcast: got src=%0d tag=%0d value=%h expected src=1 tag=7 value=00007777", cdb_src, cdb_tag, cdb_value); end
      tick();
      tick();
      vectors++; if (err_tag0 !== 1'b1) begin miscompares++; $display("FAIL tag0_err_sticky: got %b expected 1", err_tag0); end
   endtask

   // Sole requester 3 gets a grant every cycle with a fresh result each time.
   task automatic test_back_to_back();
      logic [3:0] tags [3] = '{4'd9, 4'd10, 4'd11};
      for (int k = 0; k < 3; k++) begin
         set_req(3, tags[k], 32'hB000_0000 + 32'(k), 1'b0);
         #1;
         vectors++; if (req_ready !== 5'b01000) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, req_ready, 5'b01000); end
         tick();
         vectors++; if (cdb_valid !== 1'b1 || cdb_tag !== tags[k]) begin miscompares++; $display("FAIL b2b_bcast[%0d]: got v=%b tag=%0d expected v=1 tag=%0d", k, cdb_valid, cdb_tag, tags[k]); end
      end
   endtask

   task automatic test_reset_mid();
      set_req(3, 4'd12, 32'hC000_0000, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++; if (cdb_valid !== 1'b0 || cdb_tag !== 4'd0 || cdb_src !== 3'd0)
         begin miscompares++; $display("FAIL rstmid_bcast: got v=%b tag=%0d src=%0d expected all 0", cdb_valid, cdb_tag, cdb_src); end
      vectors++; if (err_tag0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_err: got %b expected 0", err_tag0); end
      vectors++; if (req_ready !== 5'b00000) begin miscompares++; $display("FAIL rstmid_ready: got %b expected %b", req_ready, 5'b00000); end
      @(negedge clk);
      rst_n = 1'b1;
      set_req(1, 4'd4, 32'h0000_4444, 1'b0);
      #1;
      vectors++; if (req_ready !== 5'b00010) begin miscompares++; $display("FAIL rstmid_first: got %b expected %b", req_ready, 5'b00010); end
      tick();
      vectors++; if (cdb_valid !== 1'b1 || cdb_src !== 3'd1) begin miscompares++; $display("FAIL rstmid_after: got v=%b src=%0d expected v=1 src=1", cdb_valid, cdb_src); end
      clr_all();
      tick();
   endtask

`ifdef CDB_LOAD_PRIORITY_EN
   // Pointer 2, counter 0: LSQ wins 8 times, then req 2 once, then LSQ again.
   task automatic test_load_priority();
      int exp_src [10] = '{4, 4, 4, 4, 4, 4, 4, 4, 2, 4};
      for (int i = 0; i < 5; i++) set_req(i, 4'(i + 1), 32'hE000_0000 + 32'(i), 1'b0);
      for (int k = 0; k < 10; k++) begin
         #1;
         vectors++; if (req_ready !== (5'b00001 << exp_src[k])) begin miscompares++; $display("FAIL lprio_ready[%0d]: got %b expected src %0d", k, req_ready, exp_src[k]); end
         tick();
         vectors++; if (cdb_src !== 3'(exp_src[k])) begin miscompares++; $display("FAIL lprio_src[%0d]: got %0d expected %0d", k, cdb_src, exp_src[k]); end
      end
      clr_all();
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_single();
`ifndef CDB_LOAD_PRIORITY_EN
      test_round_robin();
      test_pointer();
      test_flush();
`endif
      test_tag0();
      test_back_to_back();
      test_reset_mid();
`ifdef CDB_LOAD_PRIORITY_EN
      test_load_priority();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
